// File: rtl/pipe_rr_sched_pkg.sv
// Shared defaults and helpers for the round-robin pipeline scheduler.
package pipe_rr_sched_pkg;

  localparam int unsigned DefNReq    = 4;
  localparam int unsigned DefWidth   = 36;
  localparam int unsigned DefLatency = 3;

  // Bits needed to hold values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_rr_sched_tag_delay.sv
// One-hot owner tag delay line, kept in step with the external datapath.
module tag_delay #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency pipeline among N_REQ requesters.
module pipe_rr_sched
  import pipe_rr_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned LATENCY = DefLatency
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [N_REQ-1:0]                    req,
  input  logic [N_REQ*WIDTH-1:0]              req_data,
  output logic [N_REQ-1:0]                    gnt,
  output logic                                pipe_valid,
  output logic [WIDTH-1:0]                    pipe_din,
  input  logic [WIDTH-1:0]                    pipe_dout,
  output logic [N_REQ-1:0]                    rsp_valid,
  output logic [WIDTH-1:0]                    rsp_data,
  output logic [cnt_width(LATENCY+2)-1:0]     inflight
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam int unsigned CntW = cnt_width(LATENCY + 2);

  typedef logic [PtrW-1:0] ptr_t;

  logic [WIDTH-1:0] req_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  ptr_t             ptr_q;
  ptr_t             win;
  ptr_t             cand;
  logic             found;
  logic [N_REQ-1:0] win_oh;
  logic             accept;
  logic             rsp_any;

  logic             pipe_valid_q;
  logic [WIDTH-1:0] pipe_din_q;
  logic [N_REQ-1:0] issue_tag_q;
  logic [CntW-1:0]  inflight_q, inflight_d;

  // Search starts just after the last winner so every requester is reached within N_REQ grants.
  always_comb begin
    found  = 1'b0;
    win    = ptr_q;
    cand   = '0;
    win_oh = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ptr_t'((32'(ptr_q) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_oh[win] = found;
  end

  assign accept = found & en & ~rst;
  assign gnt    = accept ? win_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= ptr_t'(N_REQ - 1);
      pipe_valid_q <= 1'b0;
      pipe_din_q   <= '0;
      issue_tag_q  <= '0;
    end else begin
      pipe_valid_q <= accept;
      issue_tag_q  <= gnt;
      if (accept) begin
        ptr_q      <= win;
        pipe_din_q <= req_arr[win];
      end
    end
  end

  tag_delay #(
    .WIDTH(N_REQ),
    .DEPTH(LATENCY)
  ) u_tag_delay (
    .clk (clk),
    .rst (rst),
    .din (issue_tag_q),
    .dout(rsp_valid)
  );

  assign rsp_any = |rsp_valid;

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, rsp_any})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign pipe_valid = pipe_valid_q;
  assign pipe_din   = pipe_din_q;
  assign rsp_data   = pipe_dout;
  assign inflight   = inflight_q;

endmodule

// File: doc/pipe_rr_sched.md
# pipe_rr_sched

Round-robin scheduler that shares one fixed-latency pipelined datapath (a chain of `delay`-style register stages or any equivalent LATENCY-cycle pipeline) among N_REQ requesters. It accepts at most one request per cycle, drives the shared pipeline input and tracks each issued operation with a one-hot owner tag. When the result emerges it returns the result to the requester that issued it. It sits between the pixel/data producers and the shared pipeline in the Basys-3 video path.

## Interface
- N_REQ, 4: number of requesters (≥2).
- WIDTH, 36: data width of requests, pipeline and responses.
- LATENCY, 3: cycles from pipeline input to pipeline output (≥1); must match the external pipeline.
- clk  in  1  posedge clock; the block's only clock.
- rst  in  1  asynchronous reset, active high.
- en  in  1  issue enable; 0 blocks all new grants.
- req  in  N_REQ  per-requester request; held until granted.
- req_data  in  N_REQ*WIDTH  request payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant (combinational); request i is accepted at the clock edge where req[i] & gnt[i] is high.
- pipe_valid  out  1  registered; an issued operation is on pipe_din.
- pipe_din  out  WIDTH  registered payload to the shared pipeline.
- pipe_dout  in  WIDTH  shared pipeline output, valid LATENCY cycles after pipe_din.
- rsp_valid  out  N_REQ  one-hot owner of the current result; all zero means no result.
- rsp_data  out  WIDTH  equals pipe_dout. It is meaningful only when rsp_valid ≠ 0.
- inflight  out  clog2(LATENCY+2)  registered count of accepted operations whose response has not yet completed.

## Operation
- Arbitration: `ptr` holds the index of the last granted requester; it resets to N_REQ-1. Search order is ptr+1, ptr+2, … wrapping modulo N_REQ. The first asserted req wins.
- gnt is all zero when en=0 or req=0. `ptr` updates only on acceptance.
- Issue register: on acceptance, pipe_valid←1, pipe_din←winning payload and issue_tag←gnt. Otherwise pipe_valid←0, issue_tag←0, and pipe_din holds its value.
- Tag tracking: issue_tag passes through a LATENCY-stage one-hot tag delay chain. The chain output is rsp_valid, so the tag stays aligned with pipe_dout. An all-zero tag is a bubble.
- inflight: +1 on acceptance, −1 in any cycle with rsp_valid≠0, unchanged when both occur. The maximum is LATENCY+1; overflow cannot occur.
- A requester may deassert req only after acceptance. Re-asserting req in the next cycle is legal; its new request competes under normal round-robin rules.
- Reset (any time, including mid-stream): ptr=N_REQ-1, pipe_valid=0, pipe_din=0, all tag stages=0, rsp_valid=0, inflight=0. In-flight operations are dropped, and no stale response may appear after rst falls.
- No backpressure exists: responses are single-cycle pulses, and requesters must sample them.

## Timing
- Request accepted in cycle k (sampled at the end of k).
- pipe_valid and pipe_din are valid in cycle k+1.
- rsp_valid and rsp_data are valid in cycle k+1+LATENCY.
- Throughput: one acceptance per cycle. Back-to-back acceptances produce back-to-back responses in the same order.
- gnt has a combinational path from req, en and ptr. All other outputs come from registers, except rsp_data, which is a passthrough.
- Reset values of all outputs: gnt=0 (with req=0), pipe_valid=0, pipe_din=0, rsp_valid=0, rsp_data=pipe_dout, inflight=0.

## Structure
- Shared package/header: default N_REQ, WIDTH and LATENCY constants, plus the clog2 width function for inflight.
- Sub-module `tag_delay`:
  - Parameters: width N_REQ, depth LATENCY.
  - Asynchronous active-high reset, clearing every stage to 0.
  - The only instance in the block.
- The round-robin search, issue register and inflight counter live in the top level. Expected size is about 150–250 lines.

## Test plan
All scenarios use N_REQ=4, WIDTH=36, LATENCY=3, and the external pipeline is modelled as a 3-stage `+1` adder.
- Reset held with req=1111 and en=1 → gnt=0000 (rst overrides), pipe_valid=0, pipe_din=0, rsp_valid=0000, inflight=0.
- Single request: req=0010, data 0x000000123, in cycle 5 → gnt=0010 in cycle 5, pipe_din=0x123 in cycle 6, rsp_valid=0010 with rsp_data=0x124 in cycle 9, inflight back to 0 after cycle 9.
- All four requesters held constantly → grant order 0,1,2,3,0,… one per cycle; responses arrive in the same order 3 cycles after issue; inflight saturates at 4.
- req=0101 held → grants alternate 0,2,0,2; requesters 1 and 3 never receive a grant or rsp_valid.
- en=0 for cycles 10–14 with req=1000 → gnt=0000 and no pipe_valid; en=1 in cycle 15 → gnt=1000 in cycle 15.
- rst pulsed in cycle 20 with 3 operations in flight → rsp_valid=0000 and inflight=0 immediately; no response for 10 cycles after release; the first grant after release goes to requester 0.
